// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the ALUOp code and datapath enables, and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  input  logic             zero_i,
  output logic [2:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             branch_taken_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_W-1:0] RETIRE_INC = CNT_W'(1);

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_SLTIU, OP_BEQ, OP_BNE,
      OP_LUI, OP_ORI, OP_LW, OP_SW: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] op);
    case (op)
      OP_R:                  return 3'd0;
      OP_ADDI, OP_LW, OP_SW: return 3'd1;
      OP_SLTIU:              return 3'd2;
      OP_BEQ:                return 3'd3;
      OP_LUI:                return 3'd4;
      OP_ORI:                return 3'd5;
      OP_BNE:                return 3'd6;
      default:               return 3'd0;
    endcase
  endfunction

  state_t     state;
  logic [5:0] op_q;
  logic       is_r, is_lw, is_sw, is_beq, is_bne, is_branch, taken;

  assign is_r      = (op_q == OP_R);
  assign is_lw     = (op_q == OP_LW);
  assign is_sw     = (op_q == OP_SW);
  assign is_beq    = (op_q == OP_BEQ);
  assign is_bne    = (op_q == OP_BNE);
  assign is_branch = is_beq || is_bne;
  assign taken     = is_beq ? zero_i : ~zero_i;

  assign state_o = state;
  assign ALUOp_o = alu_code(op_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= FETCH;
      op_q      <= '0;
      retired_o <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready_i) begin
            op_q  <= instr_op_i;
            state <= DECODE;
          end
        end
        DECODE: state <= op_legal(op_q) ? EXEC : FETCH;
        EXEC: begin
          if (is_branch) begin
            state     <= FETCH;
            retired_o <= retired_o + RETIRE_INC;
          end else if (is_lw || is_sw) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (mem_ready_i) begin
            if (is_sw) begin
              state     <= FETCH;
              retired_o <= retired_o + RETIRE_INC;
            end else begin
              state <= WB;
            end
          end
        end
        WB: begin
          state     <= FETCH;
          retired_o <= retired_o + RETIRE_INC;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Enables are gated by rst_i so nothing commits in a reset cycle, even mid-MEM-stall.
  always_comb begin
    ALUSrc_o       = 1'b0;
    RegDst_o       = 1'b0;
    RegWrite_o     = 1'b0;
    MemRead_o      = 1'b0;
    MemWrite_o     = 1'b0;
    MemtoReg_o     = 1'b0;
    IRWrite_o      = 1'b0;
    PCWrite_o      = 1'b0;
    branch_taken_o = 1'b0;
    illegal_o      = 1'b0;
    if (!rst_i) begin
      case (state)
        FETCH: begin
          MemRead_o = 1'b1;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        DECODE: illegal_o = ~op_legal(op_q);
        EXEC: begin
          ALUSrc_o = ~(is_r || is_branch);
          if (is_branch && taken) begin
            PCWrite_o      = 1'b1;
            branch_taken_o = 1'b1;
          end
        end
        MEM: begin
          MemRead_o  = is_lw;
          MemWrite_o = is_sw;
        end
        WB: begin
          RegWrite_o = 1'b1;
          RegDst_o   = is_r;
          MemtoReg_o = is_lw;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction streams compared
// cycle-by-cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, mem_ready_i, zero_i;
  logic [5:0]  instr_op_i;
  logic [2:0]  ALUOp_o, state_o;
  logic        ALUSrc_o, RegDst_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;
  logic        IRWrite_o, PCWrite_o, branch_taken_o, illegal_o;
  logic [31:0] retired_o;

  logic [2:0]  a4_ALUOp, a4_state;
  logic        a4_ALUSrc, a4_RegDst, a4_RegWrite, a4_MemRead, a4_MemWrite, a4_MemtoReg;
  logic        a4_IRWrite, a4_PCWrite, a4_branch, a4_illegal;
  logic [3:0]  a4_retired;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .zero_i(zero_i), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .MemtoReg_o(MemtoReg_o), .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o),
    .branch_taken_o(branch_taken_o), .illegal_o(illegal_o), .state_o(state_o),
    .retired_o(retired_o)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .zero_i(zero_i), .ALUOp_o(a4_ALUOp), .ALUSrc_o(a4_ALUSrc), .RegDst_o(a4_RegDst),
    .RegWrite_o(a4_RegWrite), .MemRead_o(a4_MemRead), .MemWrite_o(a4_MemWrite),
    .MemtoReg_o(a4_MemtoReg), .IRWrite_o(a4_IRWrite), .PCWrite_o(a4_PCWrite),
    .branch_taken_o(a4_branch), .illegal_o(a4_illegal), .state_o(a4_state),
    .retired_o(a4_retired)
  );

  localparam logic [5:0] R = 6'h00, ADDI = 6'h08, SLTIU = 6'h0b, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0] LUI = 6'h0f, ORI = 6'h0d, LW = 6'h23, SW = 6'h2b;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  aluop;
    logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg;
    logic        irwrite, pcwrite, br, ill;
    logic [31:0] ret;
  } obs_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_ret;
  logic [5:0]  m_opq;
  obs_t        act_q[$], exp_q[$], msk_q[$];
  logic [5:0]  op_pool[13] = '{R, ADDI, SLTIU, BEQ, BNE, LUI, ORI, LW, SW,
                               6'h3f, 6'h02, 6'h0c, 6'h21};

  function automatic logic legal(input logic [5:0] op);
    return op inside {R, ADDI, SLTIU, BEQ, BNE, LUI, ORI, LW, SW};
  endfunction

  function automatic logic [2:0] aluop_of(input logic [5:0] op);
    if (op == R)                 return 3'd0;
    if (op inside {ADDI, LW, SW}) return 3'd1;
    if (op == SLTIU)             return 3'd2;
    if (op == BEQ)               return 3'd3;
    if (op == LUI)               return 3'd4;
    if (op == ORI)               return 3'd5;
    return 3'd6;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state_o;       o.aluop = ALUOp_o;      o.alusrc = ALUSrc_o;
    o.regdst = RegDst_o;  o.regwrite = RegWrite_o; o.memread = MemRead_o;
    o.memwrite = MemWrite_o; o.memtoreg = MemtoReg_o; o.irwrite = IRWrite_o;
    o.pcwrite = PCWrite_o; o.br = branch_taken_o;  o.ill = illegal_o;
    o.ret = retired_o;
    return o;
  endfunction

  // Expected outputs for one cycle of an instruction in phase stg (0=F,1=D,2=E,3=M,4=W).
  function automatic obs_t model(input int stg, input logic [5:0] op, input logic rdy, input logic z);
    obs_t e = '0;
    logic [5:0] cur = (stg == 0) ? m_opq : op;
    logic tk;
    e.st = 3'(stg);
    e.aluop = aluop_of(cur);
    e.ret = m_ret;
    case (stg)
      0: begin e.memread = 1'b1; e.irwrite = rdy; e.pcwrite = rdy; end
      1: e.ill = ~legal(op);
      2: begin
        e.alusrc = !(op inside {R, BEQ, BNE});
        tk = (op == BEQ) ? z : ~z;
        if (op inside {BEQ, BNE}) begin e.pcwrite = tk; e.br = tk; end
      end
      3: begin e.memread = (op == LW); e.memwrite = (op == SW); end
      default: begin e.regwrite = 1'b1; e.regdst = (op == R); e.memtoreg = (op == LW); end
    endcase
    return e;
  endfunction

  function automatic obs_t mask_for(input int stg, input logic [5:0] op);
    obs_t m = '1;
    logic [5:0] cur = (stg == 0) ? m_opq : op;
    if (!legal(cur)) m.aluop = '0;
    return m;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic z, input int fst, input int mst);
    int   stg[$];
    int   n;
    logic rdy;
    stg = '{0, 1};
    if (legal(op)) begin
      stg.push_back(2);
      if (op inside {LW, SW}) stg.push_back(3);
      if (!(op inside {BEQ, BNE, SW})) stg.push_back(4);
    end
    foreach (stg[s]) begin
      n = (stg[s] == 0) ? fst + 1 : (stg[s] == 3) ? mst + 1 : 1;
      for (int k = 0; k < n; k++) begin
        rdy = (stg[s] == 0 || stg[s] == 3) ? (k == n - 1) : 1'($urandom_range(0, 1));
        rst_i = 1'b0;
        mem_ready_i = rdy;
        zero_i = (stg[s] == 2) ? z : 1'($urandom_range(0, 1));
        instr_op_i = (stg[s] == 0 && rdy) ? op : 6'($urandom);
        @(negedge clk);
        act_q.push_back(sample());
        exp_q.push_back(model(stg[s], op, rdy, z));
        msk_q.push_back(mask_for(stg[s], op));
        @(posedge clk); #1;
        if (stg[s] == 0 && rdy) m_opq = op;
      end
    end
    if (legal(op)) m_ret++;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; mem_ready_i = 1'b0; zero_i = 1'b0; instr_op_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    m_ret = 0; m_opq = '0;
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_ready_i = 1'b1; zero_i = 1'b1; instr_op_i = 6'($urandom);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({ALUSrc_o, RegDst_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
         IRWrite_o, PCWrite_o, branch_taken_o, illegal_o} !== 10'b0) begin
      errors++; $display("FAIL reset_enables got=%b want=0", {ALUSrc_o, RegDst_o, RegWrite_o,
        MemRead_o, MemWrite_o, MemtoReg_o, IRWrite_o, PCWrite_o, branch_taken_o, illegal_o});
    end
    checks++;
    if (state_o !== 3'd0 || retired_o !== 32'd0 || a4_retired !== 4'd0) begin
      errors++; $display("FAIL reset_state got st=%0d ret=%0d ret4=%0d want 0/0/0", state_o, retired_o, a4_retired);
    end
    @(posedge clk); #1;
    rst_i = 1'b0; mem_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (MemRead_o !== 1'b1 || IRWrite_o !== 1'b0 || ALUOp_o !== 3'd0) begin
      errors++; $display("FAIL reset_fetch got rd=%b ir=%b aluop=%0d want 1/0/0", MemRead_o, IRWrite_o, ALUOp_o);
    end
    @(posedge clk); #1;
    m_ret = 0; m_opq = '0;
  endtask

  task automatic test_add();
    do_reset();
    run_instr(R, 1'($urandom_range(0, 1)), 0, 0);
    mem_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 3'd0 || retired_o !== 32'd1) begin
      errors++; $display("FAIL add_retire got st=%0d ret=%0d want 0/1", state_o, retired_o);
    end
    @(posedge clk); #1;
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL add cyc%0d got=%h want=%h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  task automatic test_lw_stall();
    run_instr(LW, 1'($urandom_range(0, 1)), 0, 2);
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL lw cyc%0d got=%h want=%h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BNE, 1'b1, 0, 0);
    run_instr(BNE, 1'b0, 1, 0);
    run_instr(BEQ, 1'b0, 0, 0);
    checks++;
    if (retired_o !== 32'd4) begin
      errors++; $display("FAIL branch_retired got=%0d want=4", retired_o);
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL branch cyc%0d got=%h want=%h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  task automatic test_illegal();
    int pulses = 0;
    run_instr(6'h3f, 1'b0, 1, 0);
    foreach (act_q[i]) if (act_q[i].ill === 1'b1) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL illegal_pulses got=%0d want=1", pulses);
    end
    mem_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 3'd0 || retired_o !== m_ret) begin
      errors++; $display("FAIL illegal_after got st=%0d ret=%0d want 0/%0d", state_o, retired_o, m_ret);
    end
    @(posedge clk); #1;
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL illegal cyc%0d got=%h want=%h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  task automatic test_sw_reset();
    do_reset();
    run_instr(ADDI, 1'b0, 0, 0);
    mem_ready_i = 1'b1; instr_op_i = SW;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (state_o !== 3'd3 || MemWrite_o !== 1'b1) begin
      errors++; $display("FAIL sw_stall got st=%0d mw=%b want 3/1", state_o, MemWrite_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({RegWrite_o, MemWrite_o, MemRead_o, IRWrite_o, PCWrite_o, branch_taken_o, illegal_o} !== 7'b0) begin
      errors++; $display("FAIL sw_reset_enables got=%b want=0",
        {RegWrite_o, MemWrite_o, MemRead_o, IRWrite_o, PCWrite_o, branch_taken_o, illegal_o});
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 3'd0 || retired_o !== 32'd0) begin
      errors++; $display("FAIL sw_reset_after got st=%0d ret=%0d want 0/0", state_o, retired_o);
    end
    @(posedge clk); #1;
    m_ret = 0; m_opq = '0;
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL sw_pre cyc%0d got=%h want=%h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      run_instr(ADDI, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
      checks++;
      if (a4_retired !== 4'(i + 1)) begin
        errors++; $display("FAIL wrap4 instr%0d got=%0d want=%0d", i, a4_retired, 4'(i + 1));
      end
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL wrap cyc%0d got=%h want=%h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 60; n++) begin
      op = op_pool[$urandom_range(0, 12)];
      run_instr(op, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < act_q.size(); i++) begin
      checks++;
      if ((act_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        errors++; $display("FAIL random cyc%0d got=%h want=%h", i, act_q[i] & msk_q[i], exp_q[i] & msk_q[i]);
      end
    end
    act_q.delete(); exp_q.delete(); msk_q.delete();
  endtask

  initial begin
    rst_i = 1'b1; mem_ready_i = 1'b0; zero_i = 1'b0; instr_op_i = '0;
    m_ret = 0; m_opq = '0;
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_sw_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
